// File: rtl/bm_dag2_rx_pkg.sv
// Shared defaults, state encoding and sizing helper for the DAG result-stream receiver.
package bm_dag2_rx_pkg;

  localparam int BITS_DEF  = 2;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Index width for a table of n entries; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bm_dag2_rx_fifo.sv
// Circular synchronous FIFO with occupancy count; read data is the head entry, no bypass.
module bm_dag2_rx_fifo
  import bm_dag2_rx_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  localparam int PTR_W = idx_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ZERO_CNT = (PTR_W+1)'(0);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // A pop frees the slot the same edge, so push is accepted at full when paired with a pop.
  assign do_pop_s  = pop && (count_r != ZERO_CNT);
  assign do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= ZERO_CNT;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == ZERO_CNT);
  assign count = count_r;

endmodule

// File: rtl/bm_dag2_rx.sv
// Receiver: buffers {flag,data} result words and serialises each LSB-first on a 1-bit handshake.
module bm_dag2_rx
  import bm_dag2_rx_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [BITS-1:0]  in_data,
  input  logic             in_flag,
  output logic             in_ready,
  output logic             ser_valid,
  output logic             ser_bit,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic [CNT_W-1:0] words_sent,
  output logic             overflow
);

  localparam int WORD_W = BITS + 1;
  localparam int PTR_W  = idx_width(DEPTH);
  localparam int BC_W   = idx_width(WORD_W);
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(WORD_W - 1);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WORD_W-1:0] fifo_dout_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [PTR_W:0]    fifo_count_s;
  logic              push_s;
  logic              pop_s;
  logic              sent_inc_s;

  state_e            state_r, state_nxt_s;
  logic [WORD_W-1:0] shreg_r, shreg_nxt_s;
  logic [BC_W-1:0]   bitcnt_r, bitcnt_nxt_s;
  logic              valid_r, valid_nxt_s;
  logic              last_r, last_nxt_s;
  logic [CNT_W-1:0]  words_sent_r;
  logic              overflow_r;

  assign in_ready = (fifo_count_s != FULL_CNT);
  assign push_s   = in_valid && !fifo_full_s;

  bm_dag2_rx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_s),
    .din     ({in_flag, in_data}),
    .pop     (pop_s),
    .dout    (fifo_dout_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Next-state logic for the serialiser; outputs are the registered copies below.
  always_comb begin
    state_nxt_s  = state_r;
    shreg_nxt_s  = shreg_r;
    bitcnt_nxt_s = bitcnt_r;
    valid_nxt_s  = valid_r;
    last_nxt_s   = last_r;
    pop_s        = 1'b0;
    sent_inc_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          shreg_nxt_s  = fifo_dout_s;
          bitcnt_nxt_s = '0;
          last_nxt_s   = 1'b0;
          valid_nxt_s  = 1'b1;
          state_nxt_s  = ST_SHIFT;
        end else begin
          valid_nxt_s  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (!ser_ready) begin
          state_nxt_s = ST_SHIFT;
        end else if (last_r) begin
          sent_inc_s = 1'b1;
          // Chain straight into the next word so the stream has no idle bubble.
          if (!fifo_empty_s) begin
            pop_s        = 1'b1;
            shreg_nxt_s  = fifo_dout_s;
            bitcnt_nxt_s = '0;
            last_nxt_s   = 1'b0;
            valid_nxt_s  = 1'b1;
          end else begin
            shreg_nxt_s  = '0;
            bitcnt_nxt_s = '0;
            last_nxt_s   = 1'b0;
            valid_nxt_s  = 1'b0;
            state_nxt_s  = ST_IDLE;
          end
        end else begin
          shreg_nxt_s  = shreg_r >> 1;
          bitcnt_nxt_s = bitcnt_r + BC_W'(1);
          last_nxt_s   = ((bitcnt_r + BC_W'(1)) == LAST_IDX);
        end
      end
      default: begin
        shreg_nxt_s  = '0;
        bitcnt_nxt_s = '0;
        last_nxt_s   = 1'b0;
        valid_nxt_s  = 1'b0;
        state_nxt_s  = ST_IDLE;
      end
    endcase
  end

  // Serialiser state and registered serial outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      shreg_r  <= '0;
      bitcnt_r <= '0;
      valid_r  <= 1'b0;
      last_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      shreg_r  <= shreg_nxt_s;
      bitcnt_r <= bitcnt_nxt_s;
      valid_r  <= valid_nxt_s;
      last_r   <= last_nxt_s;
    end
  end

  // Completed-word counter (wraps) and sticky overflow on an offer while full.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      words_sent_r <= '0;
      overflow_r   <= 1'b0;
    end else begin
      if (sent_inc_s) begin
        words_sent_r <= words_sent_r + CNT_W'(1);
      end
      if (in_valid && fifo_full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign ser_valid  = valid_r;
  assign ser_bit    = shreg_r[0];
  assign ser_last   = last_r;
  assign words_sent = words_sent_r;
  assign overflow   = overflow_r;

endmodule
